coreriscv_axi4_finish_unit_ctrl: RTL and testbench

CORERISCV_AXI4_FINISH_UNIT_CTRL -- requirements
Module: coreriscv_axi4_finish_unit

---
 rtl/coreriscv_axi4_finish_unit_ctrl.sv | 147 ++++++++++++++
 tb/tb_coreriscv_axi4_finish_unit_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coreriscv_axi4_finish_unit_ctrl.sv
// Finish unit: forwards TileLink grants to the refill port and queues one Finish
// message per acknowledged grant (after the last beat for multibeat grants).
module coreriscv_axi4_finish_unit_ctrl (
    input  logic        clk,
    input  logic        reset,

    input  logic        io_grant_valid,
    output logic        io_grant_ready,
    input  logic [1:0]  io_grant_bits_header_src,
    input  logic [1:0]  io_grant_bits_header_dst,
    input  logic [2:0]  io_grant_bits_payload_addr_beat,
    input  logic        io_grant_bits_payload_client_xact_id,
    input  logic [1:0]  io_grant_bits_payload_manager_xact_id,
    input  logic        io_grant_bits_payload_is_builtin_type,
    input  logic [3:0]  io_grant_bits_payload_g_type,
    input  logic [63:0] io_grant_bits_payload_data,

    input  logic        io_refill_ready,
    output logic        io_refill_valid,
    output logic [2:0]  io_refill_bits_addr_beat,
    output logic        io_refill_bits_client_xact_id,
    output logic [1:0]  io_refill_bits_manager_xact_id,
    output logic        io_refill_bits_is_builtin_type,
    output logic [3:0]  io_refill_bits_g_type,
    output logic [63:0] io_refill_bits_data,

    input  logic        io_finish_ready,
    output logic        io_finish_valid,
    output logic [1:0]  io_finish_bits_header_src,
    output logic [1:0]  io_finish_bits_header_dst,
    output logic [1:0]  io_finish_bits_payload_manager_xact_id,

    output logic        io_ready
);

    localparam logic [1:0]        SRC_ID      = 2'd1;
    localparam int                QUEUE_DEPTH = 2;
    localparam int                DATA_BEATS  = 8;
    localparam int                BEAT_W      = $clog2(DATA_BEATS);
    localparam int                PTR_W       = $clog2(QUEUE_DEPTH);
    localparam int                CNT_W       = $clog2(QUEUE_DEPTH + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(DATA_BEATS - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR    = PTR_W'(QUEUE_DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT    = CNT_W'(QUEUE_DEPTH);

    typedef struct packed {
        logic [1:0] manager_xact_id;
        logic [1:0] manager_id;
    } finish_entry_t;

    logic              needs_ack;
    logic              multibeat;
    logic              accept_ok;
    logic              grant_fire;
    logic              beat_done;
    logic              enq;
    logic              deq;
    logic              q_full;
    logic              q_empty;
    logic [BEAT_W-1:0] beat_cnt;
    logic [PTR_W-1:0]  q_head;
    logic [PTR_W-1:0]  q_tail;
    logic [CNT_W-1:0]  q_count;
    finish_entry_t     q_mem [QUEUE_DEPTH];
    finish_entry_t     head_entry;
    logic              unused_grant_dst;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // The destination in the grant header is always this tile; it carries no information here.
    assign unused_grant_dst = ^io_grant_bits_header_dst;

    assign io_refill_bits_addr_beat       = io_grant_bits_payload_addr_beat;
    assign io_refill_bits_client_xact_id  = io_grant_bits_payload_client_xact_id;
    assign io_refill_bits_manager_xact_id = io_grant_bits_payload_manager_xact_id;
    assign io_refill_bits_is_builtin_type = io_grant_bits_payload_is_builtin_type;
    assign io_refill_bits_g_type          = io_grant_bits_payload_g_type;
    assign io_refill_bits_data            = io_grant_bits_payload_data;

    // Voluntary acks (builtin type 0) close their transaction without a Finish.
    assign needs_ack = !(io_grant_bits_payload_is_builtin_type &&
                         io_grant_bits_payload_g_type == 4'd0);
    assign multibeat = io_grant_bits_payload_is_builtin_type ?
                       (io_grant_bits_payload_g_type == 4'd5) :
                       (io_grant_bits_payload_g_type == 4'd0 ||
                        io_grant_bits_payload_g_type == 4'd1);

    assign accept_ok       = !q_full || !needs_ack;
    assign io_refill_valid = io_grant_valid && accept_ok;
    assign io_grant_ready  = io_refill_ready && accept_ok;
    assign grant_fire      = io_grant_valid && io_grant_ready;
    assign beat_done       = grant_fire && multibeat && (beat_cnt == LAST_BEAT);
    assign enq             = grant_fire && needs_ack && (!multibeat || beat_done);
    assign deq             = !q_empty && io_finish_ready;

    // Beats of one grant are never interleaved with another, so a single counter suffices.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            beat_cnt <= '0;
        end else if (grant_fire && multibeat) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // NOTE: queue storage has no reset; validity is tracked by q_count alone.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_mem[q_tail] <= '{manager_xact_id: io_grant_bits_payload_manager_xact_id,
                               manager_id:      io_grant_bits_header_src};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_head  <= '0;
            q_tail  <= '0;
            q_count <= '0;
        end else begin
            if (enq) begin
                q_tail <= next_ptr(q_tail);
            end
            if (deq) begin
                q_head <= next_ptr(q_head);
            end
            case ({enq, deq})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
        end
    end

    // Finish reads straight from storage, so a new entry appears one cycle after its enqueue.
    assign q_full     = (q_count == FULL_CNT);
    assign q_empty    = (q_count == '0);
    assign head_entry = q_mem[q_head];

    assign io_finish_valid                       = !q_empty;
    assign io_finish_bits_header_src             = SRC_ID;
    assign io_finish_bits_header_dst             = head_entry.manager_id;
    assign io_finish_bits_payload_manager_xact_id = head_entry.manager_xact_id;
    assign io_ready                              = !q_full;

endmodule

// File: tb/tb_coreriscv_axi4_finish_unit_ctrl.sv
// Self-checking bench for the finish unit: directed scenarios then random traffic,
// all compared against a queue-based reference model.
module tb_coreriscv_axi4_finish_unit_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_grant_valid;
    logic        io_grant_ready;
    logic [1:0]  io_grant_bits_header_src;
    logic [1:0]  io_grant_bits_header_dst;
    logic [2:0]  io_grant_bits_payload_addr_beat;
    logic        io_grant_bits_payload_client_xact_id;
    logic [1:0]  io_grant_bits_payload_manager_xact_id;
    logic        io_grant_bits_payload_is_builtin_type;
    logic [3:0]  io_grant_bits_payload_g_type;
    logic [63:0] io_grant_bits_payload_data;
    logic        io_refill_ready;
    logic        io_refill_valid;
    logic [2:0]  io_refill_bits_addr_beat;
    logic        io_refill_bits_client_xact_id;
    logic [1:0]  io_refill_bits_manager_xact_id;
    logic        io_refill_bits_is_builtin_type;
    logic [3:0]  io_refill_bits_g_type;
    logic [63:0] io_refill_bits_data;
    logic        io_finish_ready;
    logic        io_finish_valid;
    logic [1:0]  io_finish_bits_header_src;
    logic [1:0]  io_finish_bits_header_dst;
    logic [1:0]  io_finish_bits_payload_manager_xact_id;
    logic        io_ready;

    coreriscv_axi4_finish_unit_ctrl dut (
        .clk                                   (clk),
        .reset                                 (reset),
        .io_grant_valid                        (io_grant_valid),
        .io_grant_ready                        (io_grant_ready),
        .io_grant_bits_header_src              (io_grant_bits_header_src),
        .io_grant_bits_header_dst              (io_grant_bits_header_dst),
        .io_grant_bits_payload_addr_beat       (io_grant_bits_payload_addr_beat),
        .io_grant_bits_payload_client_xact_id  (io_grant_bits_payload_client_xact_id),
        .io_grant_bits_payload_manager_xact_id (io_grant_bits_payload_manager_xact_id),
        .io_grant_bits_payload_is_builtin_type (io_grant_bits_payload_is_builtin_type),
        .io_grant_bits_payload_g_type          (io_grant_bits_payload_g_type),
        .io_grant_bits_payload_data            (io_grant_bits_payload_data),
        .io_refill_ready                       (io_refill_ready),
        .io_refill_valid                       (io_refill_valid),
        .io_refill_bits_addr_beat              (io_refill_bits_addr_beat),
        .io_refill_bits_client_xact_id         (io_refill_bits_client_xact_id),
        .io_refill_bits_manager_xact_id        (io_refill_bits_manager_xact_id),
        .io_refill_bits_is_builtin_type        (io_refill_bits_is_builtin_type),
        .io_refill_bits_g_type                 (io_refill_bits_g_type),
        .io_refill_bits_data                   (io_refill_bits_data),
        .io_finish_ready                       (io_finish_ready),
        .io_finish_valid                       (io_finish_valid),
        .io_finish_bits_header_src             (io_finish_bits_header_src),
        .io_finish_bits_header_dst             (io_finish_bits_header_dst),
        .io_finish_bits_payload_manager_xact_id(io_finish_bits_payload_manager_xact_id),
        .io_ready                              (io_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mxid;
        logic [1:0] dst;
    } fin_t;

    int   checks  = 0;
    int   errors  = 0;
    int   dut_fin = 0;
    int   beats   = 0;
    fin_t mq[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] src, input logic builtin,
                         input logic [3:0] gt, input logic [1:0] mx);
        io_grant_valid                        = v;
        io_grant_bits_header_src              = src;
        io_grant_bits_header_dst              = 2'($urandom);
        io_grant_bits_payload_addr_beat       = 3'($urandom);
        io_grant_bits_payload_client_xact_id  = 1'($urandom);
        io_grant_bits_payload_manager_xact_id = mx;
        io_grant_bits_payload_is_builtin_type = builtin;
        io_grant_bits_payload_g_type          = gt;
        io_grant_bits_payload_data            = {$urandom, $urandom};
    endtask

    // One clock: compare at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        logic na, mb, room, exp_rdy, exp_rv, exp_fv, done;
        @(negedge clk);
        na      = !(io_grant_bits_payload_is_builtin_type && io_grant_bits_payload_g_type == 4'd0);
        mb      = io_grant_bits_payload_is_builtin_type ? (io_grant_bits_payload_g_type == 4'd5)
                  : (io_grant_bits_payload_g_type == 4'd0 || io_grant_bits_payload_g_type == 4'd1);
        room    = mq.size() < 2;
        exp_fv  = mq.size() > 0;
        exp_rdy = io_refill_ready && (room || !na);
        exp_rv  = io_grant_valid && (room || !na);
        check("refill_valid", io_refill_valid, exp_rv);
        check("grant_ready", io_grant_ready, exp_rdy);
        check("refill_meta",
              {io_refill_bits_addr_beat, io_refill_bits_client_xact_id, io_refill_bits_manager_xact_id,
               io_refill_bits_is_builtin_type, io_refill_bits_g_type},
              {io_grant_bits_payload_addr_beat, io_grant_bits_payload_client_xact_id,
               io_grant_bits_payload_manager_xact_id, io_grant_bits_payload_is_builtin_type,
               io_grant_bits_payload_g_type});
        check("refill_data", io_refill_bits_data, io_grant_bits_payload_data);
        check("io_ready", io_ready, room);
        check("finish_valid", io_finish_valid, exp_fv);
        if (exp_fv) begin
            check("finish_src", io_finish_bits_header_src, 2'd1);
            check("finish_dst", io_finish_bits_header_dst, mq[0].dst);
            check("finish_mxid", io_finish_bits_payload_manager_xact_id, mq[0].mxid);
        end
        if (io_finish_valid && io_finish_ready) dut_fin++;
        @(posedge clk);
        if (reset) begin
            mq.delete();
            beats = 0;
        end else begin
            if (exp_fv && io_finish_ready) void'(mq.pop_front());
            done = 1'b0;
            if (io_grant_valid && exp_rdy && mb) begin
                done  = (beats == 7);
                beats = (beats + 1) % 8;
            end
            if (io_grant_valid && exp_rdy && na && (!mb || done))
                mq.push_back('{mxid: io_grant_bits_payload_manager_xact_id,
                               dst:  io_grant_bits_header_src});
        end
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        io_refill_ready = 1'b0;
        io_finish_ready = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 4'd0, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_finish_valid", io_finish_valid, 1'b0);
        check("reset_io_ready", io_ready, 1'b1);

        // Single putAck: refill in the same cycle, Finish on the next.
        io_refill_ready = 1'b1;
        io_finish_ready = 1'b1;
        drive(1'b1, 2'd0, 1'b1, 4'd3, 2'd2);
        #1;
        check("putack_refill_valid", io_refill_valid, 1'b1);
        check("putack_no_flowthrough", io_finish_valid, 1'b0);
        cycle();
        drive(1'b0, 2'd0, 1'b0, 4'd0, 2'd0);
        #1;
        check("putack_finish_valid", io_finish_valid, 1'b1);
        check("putack_finish_dst", io_finish_bits_header_dst, 2'd0);
        check("putack_finish_src", io_finish_bits_header_src, 2'd1);
        check("putack_finish_mxid", io_finish_bits_payload_manager_xact_id, 2'd2);
        cycle();

        // Voluntary ack never produces a Finish.
        dut_fin = 0;
        drive(1'b1, 2'd3, 1'b1, 4'd0, 2'd1);
        cycle();
        drive(1'b0, 2'd0, 1'b0, 4'd0, 2'd0);
        repeat (3) cycle();
        check("vol_no_finish", dut_fin, 0);
        check("vol_io_ready", io_ready, 1'b1);

        // Refill back-pressure blocks the grant and leaves the beat counter alone.
        io_refill_ready = 1'b0;
        drive(1'b1, 2'd1, 1'b1, 4'd5, 2'd0);
        #1;
        check("bp_grant_ready", io_grant_ready, 1'b0);
        repeat (2) cycle();
        check("bp_no_enq", io_finish_valid, 1'b0);
        io_refill_ready = 1'b1;

        // getDataBlock: eight beats, one Finish after the last.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'd2, 1'b1, 4'd5, 2'd1);
            cycle();
            if (i < 7) check("gdb_no_early_finish", io_finish_valid, 1'b0);
        end
        drive(1'b0, 2'd0, 1'b0, 4'd0, 2'd0);
        #1;
        check("gdb_finish_valid", io_finish_valid, 1'b1);
        check("gdb_finish_dst", io_finish_bits_header_dst, 2'd2);
        check("gdb_finish_mxid", io_finish_bits_payload_manager_xact_id, 2'd1);
        cycle();

        // Fill the queue with Finish held off; third ack stalls, voluntary still passes.
        io_finish_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'(i + 1), 1'b0, 4'd3, 2'(i));
            cycle();
        end
        check("full_io_ready", io_ready, 1'b0);
        drive(1'b1, 2'd3, 1'b1, 4'd3, 2'd3);
        #1;
        check("full_grant_ready", io_grant_ready, 1'b0);
        check("full_refill_valid", io_refill_valid, 1'b0);
        cycle();
        drive(1'b1, 2'd0, 1'b1, 4'd0, 2'd0);
        #1;
        check("full_vol_grant_ready", io_grant_ready, 1'b1);
        check("full_vol_refill_valid", io_refill_valid, 1'b1);
        cycle();
        drive(1'b0, 2'd0, 1'b0, 4'd0, 2'd0);
        io_finish_ready = 1'b1;
        #1;
        check("drain0_dst", io_finish_bits_header_dst, 2'd1);
        check("drain0_mxid", io_finish_bits_payload_manager_xact_id, 2'd0);
        cycle();
        check("drain1_dst", io_finish_bits_header_dst, 2'd2);
        check("drain1_mxid", io_finish_bits_payload_manager_xact_id, 2'd1);
        repeat (2) cycle();
        check("drained_empty", io_finish_valid, 1'b0);

        // Reset in the middle of a multibeat grant abandons the partial count.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd1, 1'b1, 4'd5, 2'd3);
            cycle();
        end
        drive(1'b0, 2'd0, 1'b0, 4'd0, 2'd0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("rst_mid_finish_valid", io_finish_valid, 1'b0);
        check("rst_mid_io_ready", io_ready, 1'b1);
        dut_fin = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'd3, 1'b1, 4'd5, 2'd2);
            cycle();
            if (i < 7) check("rst_gdb_no_early_finish", io_finish_valid, 1'b0);
        end
        drive(1'b0, 2'd0, 1'b0, 4'd0, 2'd0);
        repeat (3) cycle();
        check("rst_gdb_one_finish", dut_fin, 1);

        // Random traffic with occasional resets against the reference model.
        for (int n = 0; n < 800; n++) begin
            logic [3:0] gt;
            case ($urandom_range(0, 3))
                0:       gt = 4'd0;
                1:       gt = 4'd3;
                2:       gt = 4'd5;
                default: gt = 4'($urandom);
            endcase
            drive($urandom_range(0, 3) != 0, 2'($urandom), 1'($urandom), gt, 2'($urandom));
            io_refill_ready = ($urandom_range(0, 7) != 0);
            io_finish_ready = ($urandom_range(0, 2) == 0);
            reset           = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
